// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/transmitter-side signals of the UART transmit arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  modport master (output req, data, input ack, tx_start, tx_data, busy, grant_id);
  modport slave  (input req, data, output ack, tx_start, tx_data, busy, grant_id);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte sources and times each frame.
// Define TX_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; round-robin otherwise.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int CLKS_PER_BIT = 10417,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CLKS     = 16
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int FRAME_LEN = FRAME_BITS * CLKS_PER_BIT + GAP_CLKS;
  localparam int IDW       = $clog2(NUM_REQ);
  localparam int CW        = $clog2(FRAME_LEN);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     win, idx;
  logic               hit, grant, done;
  logic [7:0]         bytes [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign bytes[g] = bus.data[8*g +: 8];
  end
  always_comb begin
    win = '0;
    idx = '0;
    hit = 1'b0;
`ifdef TX_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDW'(i);
      if (bus.req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
`else
    // search begins just past the last winner so every source gets a turn
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((int'(grant_id_q) + 1 + i) % NUM_REQ);
      if (!hit && bus.req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
`endif
    grant      = (state_q == IDLE) && hit;
    done       = (state_q == WAIT) && (cnt_q == CW'(FRAME_LEN - 1));
    state_d    = grant ? WAIT : done ? IDLE : state_q;
    cnt_d      = (state_q == WAIT && !done) ? cnt_q + 1'b1 : '0;
    busy_d     = grant ? 1'b1 : done ? 1'b0 : busy_q;
    ack_d      = grant ? NUM_REQ'(1) << win : '0;
    tx_start_d = grant;
    tx_data_d  = grant ? bytes[win] : tx_data_q;
    grant_id_d = grant ? win : grant_id_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      grant_id_q <= IDW'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      grant_id_q <= grant_id_d;
    end
  end
  assign bus.ack      = ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;
endmodule
